// File: rtl/mem_struct_loader_pkg.sv
// Shared types and constants for the struct loader: FSM states, field layout, timeout limit.
package mem_struct_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD0,
        LD1,
        LD2,
        DONE
    } state_t;

    localparam int unsigned FIELD0_OFFSET = 0;
    localparam int unsigned FIELD1_OFFSET = 8;
    localparam int unsigned FIELD2_OFFSET = 12;

    localparam int unsigned FIELD0_SIZE   = 64;
    localparam int unsigned FIELD1_SIZE   = 32;
    localparam int unsigned FIELD2_SIZE   = 16;

    localparam int unsigned TIMEOUT_W     = 8;
    localparam int unsigned TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/mem_load_unit.sv
// Single-access read engine: presents one bus request while go is high and
// returns the read data masked to the requested access size.
module mem_load_unit #(
    parameter int ADDR_W  = 32,
    parameter int SIZE_W  = 7,
    parameter int RDATA_W = 64
) (
    input  logic               go,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [SIZE_W-1:0]  size,
    input  logic [RDATA_W-1:0] rdata,
    input  logic               data_rdy,
    output logic               req_oe,
    output logic [ADDR_W-1:0]  req_addr,
    output logic [SIZE_W-1:0]  req_size,
    output logic [63:0]        data,
    output logic               ack
);

    // Request is forced to zero when idle so it can be OR-merged onto the shared bus.
    assign req_oe   = go;
    assign req_addr = go ? addr : '0;
    assign req_size = go ? size : '0;
    assign ack      = go & data_rdy;

    always_comb begin
        data = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(size)) data[i] = rdata[i];
        end
    end

endmodule

// File: rtl/mem_struct_loader.sv
// Loads a three-field struct (8/4/2 bytes) from memory with three sequential reads.
// Optional per-access timeout enabled by defining MEM_STRUCT_LOADER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start_port
// LD0   | reading field0 (64 bits at base+0)
// LD1   | reading field1 (32 bits at base+8)
// LD2   | reading field2 (16 bits at base+12)
// DONE  | one-cycle completion, done_port high
module mem_struct_loader
    import mem_struct_loader_pkg::*;
#(
    parameter int BITSIZE_inputs             = 32,
    parameter int BITSIZE_Min_addr_ram       = 32,
    parameter int BITSIZE_Mout_addr_ram      = 32,
    parameter int BITSIZE_M_Rdata_ram        = 64,
    parameter int BITSIZE_Min_Wdata_ram      = 64,
    parameter int BITSIZE_Mout_Wdata_ram     = 64,
    parameter int BITSIZE_Min_data_ram_size  = 7,
    parameter int BITSIZE_Mout_data_ram_size = 7
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start_port,
    input  logic [BITSIZE_inputs-1:0]             inputs,
    output logic                                  done_port,
    output logic [63:0]                           field0,
    output logic [31:0]                           field1,
    output logic [15:0]                           field2,
    output logic                                  err,
    input  logic                                  Min_oe_ram,
    output logic                                  Mout_oe_ram,
    input  logic                                  Min_we_ram,
    output logic                                  Mout_we_ram,
    input  logic [BITSIZE_Min_addr_ram-1:0]       Min_addr_ram,
    output logic [BITSIZE_Mout_addr_ram-1:0]      Mout_addr_ram,
    input  logic [BITSIZE_Min_Wdata_ram-1:0]      Min_Wdata_ram,
    output logic [BITSIZE_Mout_Wdata_ram-1:0]     Mout_Wdata_ram,
    input  logic [BITSIZE_Min_data_ram_size-1:0]  Min_data_ram_size,
    output logic [BITSIZE_Mout_data_ram_size-1:0] Mout_data_ram_size,
    input  logic [BITSIZE_M_Rdata_ram-1:0]        M_Rdata_ram,
    input  logic                                  M_DataRdy
);

    state_t                                  state;
    logic                                    ld_go;
    logic [BITSIZE_Mout_addr_ram-1:0]        ld_addr;
    logic [BITSIZE_Mout_data_ram_size-1:0]   ld_size;
    logic                                    own_oe;
    logic [BITSIZE_Mout_addr_ram-1:0]        own_addr;
    logic [BITSIZE_Mout_data_ram_size-1:0]   own_size;
    logic [63:0]                             ld_data;
    logic                                    ld_ack;

`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        ld_go   = 1'b0;
        ld_addr = '0;
        ld_size = '0;
        case (state)
            LD0: begin
                ld_go   = 1'b1;
                ld_addr = BITSIZE_Mout_addr_ram'(inputs) + BITSIZE_Mout_addr_ram'(FIELD0_OFFSET);
                ld_size = BITSIZE_Mout_data_ram_size'(FIELD0_SIZE);
            end
            LD1: begin
                ld_go   = 1'b1;
                ld_addr = BITSIZE_Mout_addr_ram'(inputs) + BITSIZE_Mout_addr_ram'(FIELD1_OFFSET);
                ld_size = BITSIZE_Mout_data_ram_size'(FIELD1_SIZE);
            end
            LD2: begin
                ld_go   = 1'b1;
                ld_addr = BITSIZE_Mout_addr_ram'(inputs) + BITSIZE_Mout_addr_ram'(FIELD2_OFFSET);
                ld_size = BITSIZE_Mout_data_ram_size'(FIELD2_SIZE);
            end
            default: ;
        endcase
    end

    mem_load_unit #(
        .ADDR_W  (BITSIZE_Mout_addr_ram),
        .SIZE_W  (BITSIZE_Mout_data_ram_size),
        .RDATA_W (BITSIZE_M_Rdata_ram)
    ) u_load (
        .go       (ld_go),
        .addr     (ld_addr),
        .size     (ld_size),
        .rdata    (M_Rdata_ram),
        .data_rdy (M_DataRdy),
        .req_oe   (own_oe),
        .req_addr (own_addr),
        .req_size (own_size),
        .data     (ld_data),
        .ack      (ld_ack)
    );

    // Upstream requests chain through untouched; ours is OR-merged in.
    assign Mout_oe_ram        = Min_oe_ram | own_oe;
    assign Mout_addr_ram      = BITSIZE_Mout_addr_ram'(Min_addr_ram) | own_addr;
    assign Mout_data_ram_size = BITSIZE_Mout_data_ram_size'(Min_data_ram_size) | own_size;
    assign Mout_we_ram        = Min_we_ram;
    assign Mout_Wdata_ram     = BITSIZE_Mout_Wdata_ram'(Min_Wdata_ram);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            done_port <= 1'b0;
            field0    <= '0;
            field1    <= '0;
            field2    <= '0;
`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
            err       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            done_port <= 1'b0;
`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_port) begin
                        state <= LD0;
`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                LD0, LD1, LD2: begin
                    if (ld_ack) begin
`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        case (state)
                            LD0: begin
                                field0 <= ld_data;
                                state  <= LD1;
                            end
                            LD1: begin
                                field1 <= ld_data[31:0];
                                state  <= LD2;
                            end
                            default: begin
                                field2    <= ld_data[15:0];
                                state     <= DONE;
                                done_port <= 1'b1;
                            end
                        endcase
                    end
`ifdef MEM_STRUCT_LOADER_TIMEOUT_EN
                    // The cycle that would reach the limit aborts instead of counting.
                    else if (tmo_cnt == TIMEOUT_W'(TIMEOUT_LIMIT - 1)) begin
                        state     <= DONE;
                        done_port <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_struct_loader.md
MEM_STRUCT_LOADER -- requirements
Module: mem_struct_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning): BITSIZE_inputs 32, struct base-address width; BITSIZE_Min_addr_ram/BITSIZE_Mout_addr_ram 32, bus address width; BITSIZE_M_Rdata_ram/BITSIZE_Min_Wdata_ram/BITSIZE_Mout_Wdata_ram 64, bus data width (M_Rdata_ram at least 64); BITSIZE_Min_data_ram_size/BITSIZE_Mout_data_ram_size 7, access-size width in bits.
REQ-002 SHALL have ports (name, direction, width, meaning). Reset reset, asynchronous, active-low; clock clock:
 clock in 1 clock; reset in 1 async active-low reset; start_port in 1 start request; inputs in BITSIZE_inputs struct base address; done_port out 1 completion pulse; field0 out 64 struct bytes 0-7; field1 out 32 bytes 8-11; field2 out 16 bytes 12-13; err out 1 timeout flag;
 Min_oe_ram/Mout_oe_ram in/out 1 read enable chain; Min_we_ram/Mout_we_ram in/out 1 write enable chain; Min_addr_ram/Mout_addr_ram in/out addr width, address chain; Min_Wdata_ram/Mout_Wdata_ram in/out data width, write-data chain; Min_data_ram_size/Mout_data_ram_size in/out size width, size chain; M_Rdata_ram in data width, read data; M_DataRdy in 1 read data valid.

Function
REQ-003 SHALL implement FSM states IDLE, LD0, LD1, LD2, DONE; IDLE->LD0 when start_port=1; LDn->next state on the cycle M_DataRdy=1; LD2->DONE; DONE->IDLE unconditionally.
REQ-004 In LD0/LD1/LD2 SHALL drive own request oe=1, addr=inputs+0/+8/+12, size=64/32/16, held constant until M_DataRdy=1.
REQ-005 SHALL capture M_Rdata_ram[63:0]->field0, [31:0]->field1, [15:0]->field2 on the M_DataRdy cycle of LD0/LD1/LD2 respectively; fields otherwise hold.
REQ-006 SHALL drive Mout_oe_ram, Mout_addr_ram, Mout_data_ram_size as Min_* OR own request; own request SHALL be all-zero outside LDn.
REQ-007 SHALL pass Mout_we_ram=Min_we_ram and Mout_Wdata_ram=Min_Wdata_ram unchanged; the block never writes.
REQ-008 SHALL assert done_port for exactly one cycle, in DONE only.
REQ-009 Latency: with M_DataRdy one cycle after each request, done_port SHALL be high 7 cycles after start_port is sampled.
REQ-010 SHALL ignore start_port outside IDLE and M_DataRdy outside LDn.
REQ-011 SHALL sample inputs continuously; the caller SHALL hold inputs stable from start to done_port.

Reset
REQ-012 On reset=0, at any time including mid-load, SHALL go to IDLE with done_port=0, err=0, field0/1/2=0, and own request=0 in the same cycle; Min->Mout pass-through SHALL stay active.

Configuration
REQ-013 With MEM_STRUCT_LOADER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to each LDn and increment every LDn cycle without M_DataRdy.
REQ-014 With MEM_STRUCT_LOADER_TIMEOUT_EN defined, reaching 255 SHALL abort to DONE with err=1 for that done_port cycle; remaining fields hold.
REQ-015 With MEM_STRUCT_LOADER_TIMEOUT_EN defined, err SHALL be 0 on successful completion.
REQ-016 Without MEM_STRUCT_LOADER_TIMEOUT_EN, the block SHALL wait indefinitely, err SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-017 Package mem_struct_loader_pkg SHALL hold the state enum, field offsets (0, 8, 12), field sizes (64, 32, 16) and the timeout limit (255).
REQ-018 The single-access request/capture engine SHALL be sub-module mem_load_unit (inputs addr, size, go; outputs data, ack; wraps the bus request); the FSM stays in the top.

Verification
REQ-019 inputs=0x100; memory holds 0x1122334455667788 at 0x100, 0xDEADBEEF at 0x108, 0xCAFE at 0x10C; 1-cycle DataRdy -> done_port at start+7; fields=those values; err=0.
REQ-020 DataRdy delayed 5 cycles per access -> addr/size held steady each access; done_port at start+19; fields correct.
REQ-021 start_port re-pulsed during LD1 -> ignored; single done_port pulse; no extra bus reads.
REQ-022 reset=0 during LD1 -> Mout_oe_ram=Min_oe_ram the same cycle; fields=0; new start then completes normally.
REQ-023 Min_oe_ram=1, Min_addr_ram=0x40 while IDLE -> Mout_oe_ram=1, Mout_addr_ram=0x40.
REQ-024 With TIMEOUT_EN, M_DataRdy never asserted in LD0 -> done_port and err=1 after 255 LD0 cycles; field0 unchanged.
